// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC, reads the word-addressed instruction ROM, and queues each
// returned word together with its PC in a small in-order buffer that decode
// drains over a valid/ready handshake. A redirect flushes the buffer and
// reloads the PC. A misaligned target produces a single fault-marker entry,
// after which fetch halts until the next redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_re,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_misaligned
);

    // Pointer width; DEPTH is a power of two, so pointers wrap naturally.
    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CAP = (PW+1)'(DEPTH);

    // Canonical NOP (addi x0, x0, 0) carried by a fault marker.
    localparam logic [31:0] FAULT_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FAULT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;

    // Buffer storage: data only, never reset; occupancy lives in count.
    logic [31:0] fifo_pc    [DEPTH];
    logic [31:0] fifo_instr [DEPTH];
    logic        fifo_mis   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic        deq;
    logic        space;
    logic        issue;
    logic        fault_enq;
    logic        enq;
    logic [31:0] enq_instr;
    logic        enq_mis;

    // Handshake, space and enqueue decisions for the current cycle.
    always_comb begin
        deq       = out_valid & out_ready;
        space     = (count < CAP) | deq;
        issue     = (state == RUN) & ~rst & ~redirect_valid & space;
        fault_enq = (state == FAULT) & ~rst & ~redirect_valid & space;
        enq       = issue | fault_enq;
        // ROM data is only looked at when it was actually requested.
        enq_instr = fault_enq ? FAULT_INSTR : imem_rd;
        enq_mis   = fault_enq;
    end

    assign imem_re   = issue;
    assign imem_addr = pc[31:2];

    // ---- stage boundary: ROM read data captured into the buffer ----

    // Write the enqueued entry at the tail slot.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_pc[tail]    <= pc;
            fifo_instr[tail] <= enq_instr;
            fifo_mis[tail]   <= enq_mis;
        end
    end

    // PC, FSM and buffer occupancy; redirect wins over any enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_VECTOR;
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            // A same-cycle dequeue is consumed by decode; everything else
            // still in the buffer is stale and dropped.
            pc    <= redirect_pc;
            state <= (redirect_pc[1:0] == 2'b00) ? RUN : FAULT;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (issue) begin
                pc <= pc + 32'd4;
            end
            if (fault_enq) begin
                state <= HALT;
            end
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- stage boundary: buffer head presented to decode ----

    // Head outputs, forced to zero when the buffer is empty.
    always_comb begin
        out_valid      = (count != '0);
        out_pc         = 32'h0;
        out_instr      = 32'h0;
        out_misaligned = 1'b0;
        if (out_valid) begin
            out_pc         = fifo_pc[head];
            out_instr      = fifo_instr[head];
            out_misaligned = fifo_mis[head];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: scoreboard of expected head entries checked on
// every handshake, plus directed cycle-level checks of fetch/flush timing.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_re;
    logic [29:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_misaligned;

    logic        rst_w;
    logic        imem_re_w;
    logic [29:0] imem_addr_w;
    logic [31:0] imem_rd_w;
    logic        out_valid_w;
    logic        out_ready_w;
    logic [31:0] out_instr_w;
    logic [31:0] out_pc_w;
    logic        out_misaligned_w;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_q[$];
    exp_t exp_wq[$];

    fetch_unit #(.RESET_VECTOR(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .imem_re(imem_re), .imem_addr(imem_addr),
        .imem_rd(imem_rd), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_misaligned(out_misaligned)
    );

    fetch_unit #(.RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst_w), .imem_re(imem_re_w), .imem_addr(imem_addr_w),
        .imem_rd(imem_rd_w), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .out_instr(out_instr_w), .out_pc(out_pc_w),
        .out_misaligned(out_misaligned_w)
    );

    // ROM: word k holds value k; unrequested reads return X.
    assign imem_rd   = imem_re   ? {2'b00, imem_addr}   : 32'hxxxx_xxxx;
    assign imem_rd_w = imem_re_w ? {2'b00, imem_addr_w} : 32'hxxxx_xxxx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic mis);
        exp_t e;
        e.pc = pc; e.instr = instr; e.mis = mis;
        exp_q.push_back(e);
    endtask

    task automatic push_w(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc = pc; e.instr = instr; e.mis = 1'b0;
        exp_wq.push_back(e);
    endtask

    // Hold reset for n cycles with decode stalled; return in cycle 0 after release.
    task automatic reset_cycles(input int n);
        rst = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            at_neg();
            chk("re_in_reset", 32'(imem_re), 32'd0);
            next_cyc();
        end
        rst = 1'b0;
    endtask

    // Monitor: every completed handshake must match the next expected entry.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got pc %h instr %h, required no output", out_pc, out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
                chk("sb_mis", 32'(out_misaligned), 32'(e.mis));
            end
        end
    end

    // Monitor for the wrap-around instance.
    always @(negedge clk) begin
        if (out_valid_w === 1'b1 && out_ready_w === 1'b1) begin
            if (exp_wq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wrap_out: got pc %h, required no output", out_pc_w);
            end else begin
                exp_t e;
                e = exp_wq.pop_front();
                chk("wrap_pc", out_pc_w, e.pc);
                chk("wrap_instr", out_instr_w, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        rst_w = 1'b1; out_ready_w = 1'b0;

        // Reset release and streaming with out_ready high.
        reset_cycles(2);
        out_ready = 1'b1;
        push(32'h0, 32'd0, 1'b0);
        push(32'h4, 32'd1, 1'b0);
        push(32'h8, 32'd2, 1'b0);
        push(32'hC, 32'd3, 1'b0);
        at_neg();
        chk("c0_re", 32'(imem_re), 32'd1);
        chk("c0_valid", 32'(out_valid), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            next_cyc();
            at_neg();
            chk("stream_valid", 32'(out_valid), 32'd1);
            if (c == 1) chk("first_pc", out_pc, 32'h0);
        end
        next_cyc();
        out_ready = 1'b0;
        at_neg();
        chk("midstream_valid", 32'(out_valid), 32'd1);

        // Reset asserted mid-stream.
        next_cyc();
        rst = 1'b1;
        at_neg();
        chk("re_rst_mid", 32'(imem_re), 32'd0);
        next_cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        push(32'h0, 32'd0, 1'b0);
        push(32'h4, 32'd1, 1'b0);
        at_neg();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_pc", out_pc, 32'h0);
        chk("post_rst_instr", out_instr, 32'h0);
        chk("post_rst_mis", 32'(out_misaligned), 32'd0);
        chk("post_rst_re", 32'(imem_re), 32'd1);
        chk("post_rst_addr", {2'b00, imem_addr}, 32'h0);
        next_cyc();
        at_neg();
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_pc", out_pc, 32'h0);
        next_cyc();
        at_neg();
        next_cyc();

        // Backpressure: out_ready low for 5 cycles after the first valid.
        reset_cycles(1);
        at_neg();
        chk("bp_c0_re", 32'(imem_re), 32'd1);
        next_cyc();
        at_neg();
        chk("bp_c1_valid", 32'(out_valid), 32'd1);
        chk("bp_c1_re", 32'(imem_re), 32'd1);
        for (int c = 2; c <= 5; c++) begin
            next_cyc();
            at_neg();
            chk("bp_stall_re", 32'(imem_re), 32'd0);
            chk("bp_hold_pc", out_pc, 32'h0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_addr", {2'b00, imem_addr}, 32'd2);
        end
        next_cyc();
        out_ready = 1'b1;
        push(32'h00, 32'd0, 1'b0);
        push(32'h04, 32'd1, 1'b0);
        push(32'h08, 32'd2, 1'b0);
        push(32'h0C, 32'd3, 1'b0);
        push(32'h10, 32'd4, 1'b0);
        at_neg();
        for (int c = 7; c <= 10; c++) begin
            next_cyc();
            at_neg();
        end
        next_cyc();
        out_ready = 1'b0;
        at_neg();
        chk("full_re", 32'(imem_re), 32'd0);

        // Redirect to 0x40 while full, with a same-cycle handshake.
        next_cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        out_ready = 1'b1;
        push(32'h14, 32'd5, 1'b0);
        at_neg();
        chk("redir_re", 32'(imem_re), 32'd0);
        next_cyc();
        redirect_valid = 1'b0;
        push(32'h40, 32'h10, 1'b0);
        at_neg();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("target_re", 32'(imem_re), 32'd1);
        chk("target_addr", {2'b00, imem_addr}, 32'h10);
        next_cyc();
        at_neg();
        chk("target_valid", 32'(out_valid), 32'd1);
        chk("target_pc", out_pc, 32'h40);
        next_cyc();
        out_ready = 1'b0;

        // Misaligned redirect to 0x42, then recovery via 0x80.
        next_cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        at_neg();
        chk("mis_redir_re", 32'(imem_re), 32'd0);
        next_cyc();
        redirect_valid = 1'b0;
        at_neg();
        chk("fault_valid", 32'(out_valid), 32'd0);
        chk("fault_re", 32'(imem_re), 32'd0);
        next_cyc();
        out_ready = 1'b1;
        push(32'h42, 32'h13, 1'b1);
        at_neg();
        chk("marker_valid", 32'(out_valid), 32'd1);
        chk("marker_mis", 32'(out_misaligned), 32'd1);
        chk("marker_pc", out_pc, 32'h42);
        chk("marker_instr", out_instr, 32'h13);
        chk("marker_re", 32'(imem_re), 32'd0);
        for (int c = 0; c < 2; c++) begin
            next_cyc();
            at_neg();
            chk("halt_valid", 32'(out_valid), 32'd0);
            chk("halt_re", 32'(imem_re), 32'd0);
        end
        next_cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        at_neg();
        chk("resume_redir_re", 32'(imem_re), 32'd0);
        next_cyc();
        redirect_valid = 1'b0;
        push(32'h80, 32'h20, 1'b0);
        push(32'h84, 32'h21, 1'b0);
        at_neg();
        chk("resume_re", 32'(imem_re), 32'd1);
        chk("resume_addr", {2'b00, imem_addr}, 32'h20);
        next_cyc();
        at_neg();
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_pc", out_pc, 32'h80);
        next_cyc();
        at_neg();
        next_cyc();
        out_ready = 1'b0;

        // PC wrap with RESET_VECTOR = 0xFFFF_FFF8.
        rst_w = 1'b0;
        out_ready_w = 1'b1;
        push_w(32'hFFFF_FFF8, 32'h3FFF_FFFE);
        push_w(32'hFFFF_FFFC, 32'h3FFF_FFFF);
        push_w(32'h0000_0000, 32'h0000_0000);
        at_neg();
        chk("wrap_c0_re", 32'(imem_re_w), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            next_cyc();
            at_neg();
            chk("wrap_valid", 32'(out_valid_w), 32'd1);
        end
        next_cyc();
        out_ready_w = 1'b0;

        for (int c = 0; c < 3; c++) next_cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("wrap_sb_drained", 32'(exp_wq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage between the program-counter logic and decode. Owns the PC, drives the word-addressed instruction ROM's read port, and captures each returned word with its PC into a small in-order buffer. Presents fetched instructions to decode over a valid/ready handshake. Handles control-flow redirects, including flush and misaligned-target faults.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- DEPTH, 2, output buffer entries (power of two, ≥2)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- imem_re  out  1  ROM read enable
- imem_addr  out  30  ROM word address, [31:2] of the PC
- imem_rd  in  32  ROM read data; valid by the posedge ending the cycle in which imem_re=1
- redirect_valid  in  1  load a new PC this cycle
- redirect_pc  in  32  redirect target
- out_valid  out  1  buffer head holds an instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_misaligned  out  1  head is a misaligned-fetch fault marker

## Operation
- State: pc[31:0], buffer of DEPTH entries {pc, instr, misaligned}, count[$clog2(DEPTH):0], FSM {RUN, FAULT, HALT}.
- deq = out_valid & out_ready. A dequeue is always honoured, including in a redirect cycle.
- space = (count < DEPTH) | deq.
- RUN issue = !rst & !redirect_valid & space.
  - imem_re = issue.
  - imem_addr = pc[31:2] at all times.
  - On issue: enqueue {pc, imem_rd, 0} at the posedge, then pc <= pc + 4 (wraps modulo 2^32).
- imem_rd is never sampled when imem_re=0. The ROM returns X in that case.
- Redirect (any state, priority over issue): clear buffer (count <= 0; a same-cycle deq still counts as consumed), then pc <= redirect_pc.
  - redirect_pc[1:0] == 0: state <= RUN.
  - Otherwise: state <= FAULT.
- FAULT: imem_re=0. If space, enqueue {pc, 32'h0000_0013, 1} and state <= HALT.
- HALT: imem_re=0, no enqueues; buffer drains normally. Leaves only on redirect or reset.
- Empty buffer: out_instr, out_pc, out_misaligned all 0.
- Simultaneous enqueue+dequeue when full: allowed; count unchanged.

## Timing
- Reset (rst high at a posedge) sets:
  - pc = RESET_VECTOR
  - count = 0, state = RUN
  - out_valid = 0, out_* = 0
- imem_re = 0 while rst is high.
- Reset mid-operation discards the buffer and any in-cycle fetch.
- Fetch-to-output latency is 1 cycle. A word requested in cycle N appears at the head in cycle N+1 if the buffer was empty.
- First instruction after reset: rst low in cycle 0, then imem_re=1 in cycle 0, then out_valid=1 in cycle 1 with out_pc=RESET_VECTOR.
- Sustained throughput with out_ready held high: 1 instruction/cycle, no bubbles.
- Redirect in cycle N:
  - no fetch in N;
  - target fetched in N+1;
  - out_valid=1 with out_pc=target in N+2;
  - no stale instruction appears after N.
- out_ready low: buffer fills in DEPTH cycles, then imem_re=0 until a dequeue. Head outputs stay stable while out_valid & !out_ready.
- Misaligned redirect in N: fault marker at head in N+2 (given space), then out_valid=0 once it is consumed.

## Test plan
- Reset release, RESET_VECTOR=0, ROM word k = k, out_ready=1: out_pc sequence 0,4,8,12 with out_instr 0,1,2,3 on consecutive cycles from cycle 1; imem_re=0 during reset.
- Backpressure: out_ready=0 for 5 cycles after the first valid. Required: count saturates at 2, imem_re=0 afterwards, head held at pc=0. Releasing out_ready resumes pc 4,8,… with no drop or duplicate.
- Redirect to 0x40 while the buffer is full and out_ready=1 in the same cycle: the head handshake completes, the buffer is flushed, and the next out_pc=0x40 arrives exactly 2 cycles later.
- Redirect to 0x42: one entry appears with out_misaligned=1, out_pc=0x42, out_instr=0x00000013. imem_re stays 0 until a redirect to 0x80, which resumes normal fetch.
- PC wrap: RESET_VECTOR=32'hFFFF_FFF8 gives out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-stream with out_valid=1: the next cycle has out_valid=0 and all out_*=0, and fetch restarts at RESET_VECTOR.
